// File: rtl/tdc_meas_ctrl_if.sv
// Measurement-sequencer bus: hit levels, arm request, coarse-counter strobes and readout handshake.
// The master modport is the sequencer; the slave modport is the surrounding datapath/readout.
interface tdc_meas_ctrl_if;
    logic iArm;
    logic iStart;
    logic iStop;
    logic iReady;
    logic oCntRst;
    logic oCntCE;
    logic oStore;
    logic oValid;
    logic oTimeout;
    logic oMiss;
    logic oBusy;

    modport master (
        input  iArm, iStart, iStop, iReady,
        output oCntRst, oCntCE, oStore, oValid, oTimeout, oMiss, oBusy
    );

    modport slave (
        output iArm, iStart, iStop, iReady,
        input  oCntRst, oCntCE, oStore, oValid, oTimeout, oMiss, oBusy
    );
endinterface

// File: rtl/tdc_meas_ctrl.sv
// TDC measurement sequencer: drives coarse-counter reset/enable/store from start/stop edges, with timeout.
// Optional macro TDC_MEAS_CTRL_AUTOARM_EN: a completed handshake re-arms directly (VALID -> ARMED).
module tdc_meas_ctrl #(
    parameter int C_DIG = 10
) (
    input  logic                  clk,
    input  logic                  iRst,
    tdc_meas_ctrl_if.master       bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_RUN,
        S_STORE,
        S_WAIT,
        S_VALID
    } state_t;

    // Last elapsed value before timeout: TMAX - 1 = 2^C_DIG - 2.
    localparam logic [C_DIG-1:0] EL_LAST = {{(C_DIG-1){1'b1}}, 1'b0};

    state_t           state_q, state_d;
    logic [C_DIG-1:0] el_q, el_d;
    logic             tf_q, tf_d;
    logic             miss_q, miss_d;
    logic             s_start_q, s_stop_q;
    logic             cnt_rst_q, cnt_ce_q, store_q, valid_q, timeout_q, busy_q;
    logic             st_edge, sp_edge, any_edge;

    assign st_edge  = bus.iStart & ~s_start_q;
    assign sp_edge  = bus.iStop  & ~s_stop_q;
    assign any_edge = st_edge | sp_edge;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
        state_d = state_q;
        el_d    = el_q;
        tf_d    = tf_q;
        miss_d  = miss_q;
        case (state_q)
            S_IDLE: begin
                if (bus.iArm) begin
                    state_d = S_ARMED;
                    miss_d  = 1'b0;
                end
            end
            S_ARMED: begin
                if (st_edge) begin
                    el_d    = '0;
                    state_d = sp_edge ? S_STORE : S_RUN;
                end
            end
            S_RUN: begin
                el_d = el_q + 1'b1;
                if (st_edge) miss_d = 1'b1;
                if (sp_edge) begin
                    state_d = S_STORE;
                end else if (el_q == EL_LAST) begin
                    state_d = S_STORE;
                    tf_d    = 1'b1;
                end
            end
            S_STORE: begin
                if (any_edge) miss_d = 1'b1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (any_edge) miss_d = 1'b1;
                state_d = S_VALID;
            end
            S_VALID: begin
                if (any_edge) miss_d = 1'b1;
                if (bus.iReady) begin
                    tf_d = 1'b0;
`ifdef TDC_MEAS_CTRL_AUTOARM_EN
                    state_d = S_ARMED;
                    miss_d  = 1'b0;
`else
                    state_d = S_IDLE;
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output flops are loaded from the next state, so each output is a clean decode of the state register.
    always_ff @(posedge clk) begin
        if (iRst) begin
            state_q   <= S_IDLE;
            el_q      <= '0;
            tf_q      <= 1'b0;
            miss_q    <= 1'b0;
            s_start_q <= 1'b0;
            s_stop_q  <= 1'b0;
            cnt_rst_q <= 1'b1;
            cnt_ce_q  <= 1'b0;
            store_q   <= 1'b0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q   <= state_d;
            el_q      <= el_d;
            tf_q      <= tf_d;
            miss_q    <= miss_d;
            s_start_q <= bus.iStart;
            s_stop_q  <= bus.iStop;
            cnt_rst_q <= (state_d == S_IDLE) || (state_d == S_ARMED);
            cnt_ce_q  <= (state_d == S_RUN);
            store_q   <= (state_d == S_STORE);
            valid_q   <= (state_d == S_VALID);
            timeout_q <= (state_d == S_VALID) && tf_d;
            busy_q    <= (state_d == S_RUN) || (state_d == S_STORE);
        end
    end

    assign bus.oCntRst  = cnt_rst_q;
    assign bus.oCntCE   = cnt_ce_q;
    assign bus.oStore   = store_q;
    assign bus.oValid   = valid_q;
    assign bus.oTimeout = timeout_q;
    assign bus.oMiss    = miss_q;
    assign bus.oBusy    = busy_q;

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// Scoreboard bench for tdc_meas_ctrl with a behavioural coarse counter standing in for the datapath.
// Stimulus pushes expected results; a negedge monitor pops and compares when oValid rises.
module tb_tdc_meas_ctrl;

    localparam int C_DIG = 4;
    localparam int TMAX  = (1 << C_DIG) - 1;

    typedef struct {
        int n;
        bit to;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tdc_meas_ctrl_if bus ();

    tdc_meas_ctrl #(.C_DIG(C_DIG)) dut (
        .clk  (clk),
        .iRst (rst),
        .bus  (bus)
    );

    // Coarse counter stand-in driven by the sequencer strobes.
    logic [C_DIG-1:0] cnt, stored;
    always @(posedge clk) begin
        if (bus.oCntRst)     cnt <= '0;
        else if (bus.oCntCE) cnt <= cnt + 1'b1;
        if (bus.oStore)      stored <= cnt;
    end

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_pop    = 0;
    exp_t sb[$];
    bit   seen     = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: one comparison set per result presentation.
    always @(negedge clk) begin
        if (bus.oValid && !seen) begin
            exp_t e;
            seen = 1'b1;
            if (sb.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                n_pop++;
                check("result", {28'd0, stored}, e.n);
                check("timeout_flag", {31'd0, bus.oTimeout}, {31'd0, e.to});
            end
        end else if (!bus.oValid) begin
            seen = 1'b0;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic arm();
        bus.iArm = 1'b1;
        tick();
        bus.iArm = 1'b0;
    endtask

    task automatic handshake();
        bus.iReady = 1'b1;
        tick();
        bus.iReady = 1'b0;
    endtask

    task automatic wait_valid();
        int n = 0;
        while (!bus.oValid && n < 20) begin
            tick();
            n++;
        end
        check("valid_wait", {31'd0, bus.oValid}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cntrst"},  {31'd0, bus.oCntRst},  32'd1);
        check({tag, "_ce"},      {31'd0, bus.oCntCE},   32'd0);
        check({tag, "_store"},   {31'd0, bus.oStore},   32'd0);
        check({tag, "_valid"},   {31'd0, bus.oValid},   32'd0);
        check({tag, "_timeout"}, {31'd0, bus.oTimeout}, 32'd0);
        check({tag, "_miss"},    {31'd0, bus.oMiss},    32'd0);
        check({tag, "_busy"},    {31'd0, bus.oBusy},    32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bus.iArm   = 1'b0;
        bus.iStart = 1'b0;
        bus.iStop  = 1'b0;
        bus.iReady = 1'b0;
        rst        = 1'b1;
        tick(2);
        check_reset_outputs("reset");
        rst = 1'b0;
        tick();
        check("cnt_after_reset", {28'd0, cnt}, 32'd0);

        // Basic: stop 7 cycles after start.
        arm();
        check("armed_cntrst", {31'd0, bus.oCntRst}, 32'd1);
        check("armed_busy",   {31'd0, bus.oBusy},   32'd0);
        sb.push_back('{7, 1'b0});
        bus.iStart = 1'b1;
        tick();
        check("run_ce",     {31'd0, bus.oCntCE},  32'd1);
        check("run_busy",   {31'd0, bus.oBusy},   32'd1);
        check("run_cntrst", {31'd0, bus.oCntRst}, 32'd0);
        tick(6);
        bus.iStop = 1'b1;
        tick();
        check("store_strobe", {31'd0, bus.oStore}, 32'd1);
        check("store_ce",     {31'd0, bus.oCntCE}, 32'd0);
        tick();
        check("wait_valid_low", {31'd0, bus.oValid}, 32'd0);
        tick();
        check("valid_latency", {31'd0, bus.oValid}, 32'd1);
        bus.iStart = 1'b0;
        bus.iStop  = 1'b0;
        handshake();
        check("valid_drop",   {31'd0, bus.oValid},  32'd0);
        check("idle_cntrst",  {31'd0, bus.oCntRst}, 32'd1);

        // Timeout: no stop, STORE after TMAX RUN cycles.
        arm();
        sb.push_back('{TMAX, 1'b1});
        bus.iStart = 1'b1;
        tick();
        n = 0;
        while (!bus.oStore && n < 40) begin
            tick();
            n++;
        end
        check("timeout_cycles", n, TMAX);
        wait_valid();
        check("timeout_out", {31'd0, bus.oTimeout}, 32'd1);
        bus.iStart = 1'b0;
        handshake();
        check("timeout_cleared", {31'd0, bus.oTimeout}, 32'd0);

        // Simultaneous start and stop in ARMED: zero-length.
        arm();
        sb.push_back('{0, 1'b0});
        bus.iStart = 1'b1;
        bus.iStop  = 1'b1;
        tick();
        check("zero_store", {31'd0, bus.oStore}, 32'd1);
        check("zero_ce",    {31'd0, bus.oCntCE}, 32'd0);
        wait_valid();
        bus.iStart = 1'b0;
        bus.iStop  = 1'b0;
        handshake();

        // Miss: second start edge while running.
        arm();
        sb.push_back('{4, 1'b0});
        bus.iStart = 1'b1;
        tick(2);
        bus.iStart = 1'b0;
        tick();
        bus.iStart = 1'b1;
        tick();
        check("run_start_miss", {31'd0, bus.oMiss}, 32'd1);
        bus.iStop = 1'b1;
        tick();
        wait_valid();
        bus.iStart = 1'b0;
        bus.iStop  = 1'b0;
        handshake();

        // Backpressure, plus a stop edge while VALID.
        arm();
        check("miss_cleared", {31'd0, bus.oMiss}, 32'd0);
        sb.push_back('{3, 1'b0});
        bus.iStart = 1'b1;
        tick(3);
        bus.iStop = 1'b1;
        tick();
        wait_valid();
        bus.iStart = 1'b0;
        bus.iStop  = 1'b0;
        tick();
        check("bp_miss_pre", {31'd0, bus.oMiss}, 32'd0);
        for (int i = 0; i < 20; i++) begin
            if (i == 10) bus.iStop = 1'b1;
            check("bp_valid",  {31'd0, bus.oValid}, 32'd1);
            check("bp_result", {28'd0, stored},     32'd3);
            tick();
        end
        check("valid_stop_miss", {31'd0, bus.oMiss}, 32'd1);
        bus.iStop = 1'b0;
        handshake();
        check("bp_valid_drop", {31'd0, bus.oValid}, 32'd0);

`ifdef TDC_MEAS_CTRL_AUTOARM_EN
        // Auto-arm: a measurement runs without a new iArm.
        check("autoarm_cntrst", {31'd0, bus.oCntRst}, 32'd1);
        check("autoarm_miss",   {31'd0, bus.oMiss},   32'd0);
        sb.push_back('{3, 1'b0});
        bus.iStart = 1'b1;
        tick();
        check("autoarm_run", {31'd0, bus.oBusy}, 32'd1);
        tick(2);
        bus.iStop = 1'b1;
        tick();
        wait_valid();
        bus.iStart = 1'b0;
        bus.iStop  = 1'b0;
        handshake();
`else
        // Without arming, a start edge must not begin a measurement.
        bus.iStart = 1'b1;
        tick();
        check("no_arm_no_run", {31'd0, bus.oBusy}, 32'd0);
        bus.iStart = 1'b0;
        tick();
`endif

        // Reset in the middle of RUN, with oMiss set.
        arm();
        bus.iStart = 1'b1;
        tick(2);
        bus.iStart = 1'b0;
        tick();
        bus.iStart = 1'b1;
        tick();
        check("pre_reset_miss", {31'd0, bus.oMiss}, 32'd1);
        rst = 1'b1;
        tick();
        rst        = 1'b0;
        bus.iStart = 1'b0;
        check_reset_outputs("midrun_reset");
        tick();
        check("cnt_cleared_after_reset", {28'd0, cnt}, 32'd0);
        tick(5);

        check("scoreboard_empty", sb.size(), 32'd0);
`ifdef TDC_MEAS_CTRL_AUTOARM_EN
        check("results_seen", n_pop, 32'd6);
`else
        check("results_seen", n_pop, 32'd5);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tdc_meas_ctrl.md
# tdc_meas_ctrl

Measurement sequencer that sits directly upstream of the coarse clock counter in the TDC datapath. It turns synchronized start/stop hit levels into the counter's reset, count-enable and store strobes. It guards against a missing stop with a timeout. It presents each finished measurement to the readout logic with a valid/ready handshake.

## Interface
Parameters:
- C_DIG, 10, coarse counter width; sets the timeout limit TMAX = 2^C_DIG - 1.

Ports:
- clk  in  1  system clock; the same clock as the coarse counter.
- iRst  in  1  reset, synchronous, active-high.
- iArm  in  1  level; request to arm for the next measurement.
- iStart  in  1  synchronized start hit level; only a rising edge is used.
- iStop  in  1  synchronized stop hit level; only a rising edge is used.
- iReady  in  1  readout accepts the result.
- oCntRst  out  1  drives the coarse counter iRst.
- oCntCE  out  1  drives the coarse counter iCE.
- oStore  out  1  drives the coarse counter iStore.
- oValid  out  1  result held in the counter's stored register is valid.
- oTimeout  out  1  the current result ended by timeout, not by a stop; meaningful while oValid = 1.
- oMiss  out  1  sticky flag: a start or stop edge arrived while the block was not able to use it.
- oBusy  out  1  block is in RUN or STORE.

## Operation
- Edge detect: registers sS and sP hold iStart and iStop from the previous cycle and update every cycle. Reset value is 0.
  - Start edge: stE = iStart & ~sS.
  - Stop edge: spE = iStop & ~sP.
- FSM states: IDLE, ARMED, RUN, STORE, WAIT, VALID. Reset state is IDLE.
- IDLE: oCntRst = 1. Moves to ARMED when iArm = 1.
- ARMED: oCntRst = 1. Moves as follows:
  - stE = 1 and spE = 0 → RUN.
  - stE = 1 and spE = 1 → STORE. This is a zero-length measurement; the count stays 0.
  - A spE without a stE is ignored.
- RUN: oCntCE = 1. An internal elapsed counter el (C_DIG bits) is cleared on entry and increments once per RUN cycle. Moves as follows:
  - spE = 1 → STORE.
  - el = TMAX - 1 with no spE → STORE, and the timeout flag tf is set.
  - Any stE in RUN sets oMiss and is ignored.
- STORE: oStore = 1 and oCntCE = 0. Moves unconditionally to WAIT. WAIT exists so the counter's stored register has settled.
- WAIT: moves unconditionally to VALID.
- VALID: oValid = 1 and oTimeout = tf. Moves on oValid & iReady:
  - To IDLE by default; tf is cleared.
  - See Configuration for the auto-arm alternative.
- oMiss: set by any stE or spE in STORE, WAIT or VALID, and by any stE in RUN. Cleared on IDLE→ARMED and by iRst.
- Result value: the counter holds the number of RUN cycles N, where 1 ≤ N ≤ TMAX. The zero-length path gives N = 0. A timeout gives N = TMAX. No wrap-around can occur.
- Outputs are pure decodes of the registered state (Moore). oTimeout and oMiss come from registers. No output depends combinationally on any input.

## Timing
- Reset: iRst is sampled at an edge. After that edge:
  - State = IDLE, oCntRst = 1.
  - oCntCE, oStore, oValid, oTimeout, oMiss and oBusy are all 0.
  - tf, el, sS and sP are all 0.
- Reset mid-measurement: the FSM returns to IDLE on the next edge, and the counter is cleared one edge later. Any pending result is discarded without a handshake.
- Start latency: a stE sampled at edge k puts the FSM in RUN from k+1. The counter's first increment is at edge k+2.
- Stop latency: a spE sampled at edge m in RUN puts the FSM in STORE from m+1. The counter captures at edge m+2. oValid is asserted from m+3 (after WAIT).
- Handshake: oValid holds until the edge where iReady = 1. oValid drops on the next cycle. iReady while oValid = 0 is ignored.
- Timeout: with no stop, STORE is entered exactly TMAX cycles after RUN is entered.

## Configuration
- TDC_MEAS_CTRL_AUTOARM_EN defined: a completed handshake goes VALID→ARMED directly. oCntRst is asserted in that ARMED cycle, and oMiss is cleared as on IDLE→ARMED. iArm is ignored outside IDLE.
- Not defined: VALID→IDLE, so a new iArm is needed for every measurement.

## Test plan
- Basic: arm; start edge; stop edge 7 cycles after the start edge (in RUN) → 7 RUN cycles; counter result = 7; oValid 3 cycles after the stop; oTimeout = 0; iReady → IDLE.
- Timeout: C_DIG = 4; start edge with no stop → STORE after 15 RUN cycles; result = 15; oTimeout = 1 while oValid = 1.
- Simultaneous: iStart and iStop rise in the same ARMED cycle → RUN is skipped; result = 0; oTimeout = 0.
- Miss: a second start edge in RUN, plus a stop edge while in VALID → oMiss = 1; result unaffected; oMiss cleared on the next arm.
- Backpressure and reset: hold iReady = 0 for 20 cycles → oValid and the result are stable; then assert iRst in RUN of the next measurement → IDLE, outputs at reset values, counter reads 0.
- Auto-arm (macro defined): handshake → ARMED next cycle with no iArm; a following start/stop 3 RUN cycles apart → result = 3.
